rr_arbiter_4: RTL and testbench
===============================

// Module: rr_arbiter_4
// PURPOSE
//  Round-robin arbiter sharing one resource among 4 requesters. The winner is held as a 2-bit index
//  and driven out through a 2-to-4 one-hot grant decode. Sits in front of any shared datapath that
//  is selected by a 2x4 decoder; the grant vector can drive the datapath select lines directly.
//  Grants are sticky: the winner keeps the resource until it drops its request.
// PARAMETERS
//  TIMEOUT_CYCLES  16  max cycles one grant may be held (used only with RR_ARB_TIMEOUT_EN); >=2
//  CNT_W           5   hold-counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst        in   1  synchronous, active-high reset
//  en         in   1  arbiter enable; low = no new grants, active grant revoked
//  req        in   4  request per requester, level; held high for the whole tenure
//  gnt        out  4  one-hot grant = decode(gnt_idx) when gnt_valid, else 4'b0000
//  gnt_idx    out  2  index of current grant holder
//  gnt_valid  out  1  a grant is active
//  timeout    out  1  1-cycle pulse: grant revoked by hold timeout
// BEHAVIOUR
//  Reset (rst=1 at edge, overrides everything incl. mid-tenure): state=IDLE, ptr=0, gnt_idx=0,
//   gnt_valid=0, gnt=0000, timeout=0, hold counter=0.
//  ptr = 2-bit round-robin start point; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4, 3 wraps to 0).
//  FSM states: IDLE, BUSY. All outputs registered.
//  IDLE: if en=1 and req!=0 -> first set req bit in search order becomes gnt_idx, gnt_valid=1,
//   -> BUSY at the same edge. Latency: req sampled at edge N, gnt visible after edge N (1 cycle).
//   en=0 or req=0 -> stay IDLE, outputs 0.
//  BUSY: gnt stays constant while req[gnt_idx]=1 and en=1; other req bits are ignored.
//   Release: req[gnt_idx]=0 at an edge -> gnt_valid=0, ptr=gnt_idx+1, -> IDLE.
//   Revoke: en=0 at an edge -> identical to release (ptr advances past the revoked holder).
//   Minimum one dead cycle (gnt=0000) between consecutive grants; no back-to-back grants.
//  gnt is never multi-hot; gnt=0000 whenever gnt_valid=0.
//  Simultaneous events, priority order: rst > release/en=0 > timeout. Release or en=0 in the
//   same cycle as the timeout threshold -> normal release, timeout stays 0.
//  req changes on non-holders during BUSY have no effect; the holder's request is level-sampled.
// CONFIGURATION
//  RR_ARB_TIMEOUT_EN defined:
//   hold counter clears on entry to BUSY and increments every BUSY cycle.
//   When the count reaches TIMEOUT_CYCLES-1 with req[gnt_idx] still 1: revoke at that edge
//   (gnt_valid=0, ptr=gnt_idx+1, -> IDLE) and timeout=1 for exactly one cycle.
//   Total grant length is therefore TIMEOUT_CYCLES cycles. If the same requester still requests,
//   it may win again after the dead cycle if no other requester is ahead in search order.
//  RR_ARB_TIMEOUT_EN undefined: no counter logic; timeout tied 0; grants held indefinitely;
//   TIMEOUT_CYCLES and CNT_W are unused.
// TESTING
//  T1 rst=1 two edges, then check gnt=0000, gnt_idx=0, gnt_valid=0, timeout=0.
//  T2 en=1, req=0101 -> gnt=0001 one edge later; drop req[0] -> one 0000 cycle, then gnt=0100.
//  T3 req=1111, each holder releases after 2 cycles and re-requests -> grant order 0,1,2,3,0
//     (wrap); always one dead cycle between grants.
//  T4 grant to req[1] held, en=0 for one cycle -> gnt=0000 next edge; en=1, req=0011 -> gnt=0001
//     (ptr=2 wraps to 0).
//  T5 [RR_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4] req=0100 held -> gnt=0100 for 4 cycles, timeout=1 one
//     cycle with gnt=0000, then gnt=0100 again; without macro gnt stays 0100 and timeout stays 0.
//  T6 rst=1 mid-tenure with gnt=1000 -> all outputs 0 next edge; next grant search starts at 0.

Source files
------------

// File: rtl/rr_arbiter_4.sv
// Round-robin arbiter for 4 requesters with sticky grants and a one-hot grant decode.
// Optional hold timeout is built in when RR_ARB_TIMEOUT_EN is defined.
module rr_arbiter_4 #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    logic [1:0] ptr;
    logic [1:0] pick_idx;
    logic       pick_valid;
    logic [1:0] cand;
    logic       hold_expired;

    // Reject configurations where the hold counter cannot reach the threshold.
    if (TIMEOUT_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("rr_arbiter_4: need TIMEOUT_CYCLES >= 2 and 2**CNT_W > TIMEOUT_CYCLES");
    end

    // Walk from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        pick_idx   = ptr;
        pick_valid = 1'b0;
        cand       = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_cnt;
    assign hold_expired = (hold_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign hold_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 2'd0;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            gnt       <= 4'b0000;
            timeout   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pick_valid) begin
                        state     <= BUSY;
                        gnt_idx   <= pick_idx;
                        gnt_valid <= 1'b1;
                        gnt       <= 4'(1) << pick_idx;
`ifdef RR_ARB_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                BUSY: begin
                    // Release and revoke outrank the timeout when they coincide.
                    if (!en || !req[gnt_idx] || hold_expired) begin
                        state     <= IDLE;
                        ptr       <= gnt_idx + 2'd1;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                        gnt       <= 4'b0000;
                        timeout   <= en && req[gnt_idx] && hold_expired;
                    end
`ifdef RR_ARB_TIMEOUT_EN
                    else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed self-checking bench for rr_arbiter_4; timeout checks follow RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int total = 0;
    int bad   = 0;

    rr_arbiter_4 #(.TIMEOUT_CYCLES(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic       exp_to;

        // T1: reset
        rst = 1'b1; en = 1'b0; req = 4'b0000;
        step(); step();
        chk("t1_gnt", gnt, 4'b0000);
        chk("t1_idx", {2'b00, gnt_idx}, 4'd0);
        chk("t1_valid", {3'b000, gnt_valid}, 4'd0);
        chk("t1_timeout", {3'b000, timeout}, 4'd0);
        rst = 1'b0;

        // T2: lowest in search order wins, dead cycle, then next requester
        en = 1'b1; req = 4'b0101;
        step();
        chk("t2_gnt0", gnt, 4'b0001);
        chk("t2_idx0", {2'b00, gnt_idx}, 4'd0);
        chk("t2_valid0", {3'b000, gnt_valid}, 4'd1);
        req = 4'b0100;
        step();
        chk("t2_dead", gnt, 4'b0000);
        chk("t2_dead_valid", {3'b000, gnt_valid}, 4'd0);
        step();
        chk("t2_gnt2", gnt, 4'b0100);
        chk("t2_idx2", {2'b00, gnt_idx}, 4'd2);
        req = 4'b0000;
        step();
        chk("t2_rel", gnt, 4'b0000);

        // T3: full rotation with wrap, pointer restarted at 0 by reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_gnt = 4'b0001 << (k % 4);
            step();
            chk($sformatf("t3_gnt_%0d", k), gnt, exp_gnt);
            step();
            chk($sformatf("t3_hold_%0d", k), gnt, exp_gnt);
            req = 4'b1111 & ~exp_gnt;
            step();
            chk($sformatf("t3_dead_%0d", k), gnt, 4'b0000);
            req = 4'b1111;
        end
        req = 4'b0000;
        step();

        // T4: revoke via en=0, pointer moves past the revoked holder and wraps
        req = 4'b0010;
        step();
        chk("t4_gnt1", gnt, 4'b0010);
        en = 1'b0;
        step();
        chk("t4_revoke", gnt, 4'b0000);
        chk("t4_revoke_valid", {3'b000, gnt_valid}, 4'd0);
        en = 1'b1; req = 4'b0011;
        step();
        chk("t4_wrap", gnt, 4'b0001);
        req = 4'b0000;
        step();

        // T5: holder keeps requesting
        req = 4'b0100;
        step();
        chk("t5_start", gnt, 4'b0100);
        for (int i = 0; i < 6; i++) begin
`ifdef RR_ARB_TIMEOUT_EN
            exp_gnt = (i == 3) ? 4'b0000 : 4'b0100;
            exp_to  = (i == 3);
`else
            exp_gnt = 4'b0100;
            exp_to  = 1'b0;
`endif
            step();
            chk($sformatf("t5_gnt_%0d", i), gnt, exp_gnt);
            chk($sformatf("t5_to_%0d", i), {3'b000, timeout}, {3'b000, exp_to});
        end
        req = 4'b0000;
        step();
        chk("t5_rel_to", {3'b000, timeout}, 4'd0);

        // T6: reset mid-tenure, then search restarts at 0
        req = 4'b1000;
        step();
        chk("t6_gnt3", gnt, 4'b1000);
        rst = 1'b1;
        step();
        chk("t6_gnt", gnt, 4'b0000);
        chk("t6_idx", {2'b00, gnt_idx}, 4'd0);
        chk("t6_valid", {3'b000, gnt_valid}, 4'd0);
        chk("t6_timeout", {3'b000, timeout}, 4'd0);
        rst = 1'b0; req = 4'b1001;
        step();
        chk("t6_after", gnt, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
